// File: rtl/countup_nbits_pkg.sv
// Shared types and constants for the count-up timer and its 7-segment display path.
package countup_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Active-low segment patterns, bit0 = a ... bit6 = g
    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/countup_nbits_if.sv
// Control/status bundle of the count-up timer.
//   start, pause, target : controls into the timer
//   countupOut, done     : registered count and completion flag
//   led1, led2           : ones / tens digit, active-low 7-segment
interface countup_nbits_if #(
    parameter int unsigned N = 6
) ();

    logic         start;
    logic         pause;
    logic [N-1:0] target;
    logic [N-1:0] countupOut;
    logic         done;
    logic [6:0]   led1;
    logic [6:0]   led2;

    modport master (
        output start, pause, target,
        input  countupOut, done, led1, led2
    );

    modport slave (
        input  start, pause, target,
        output countupOut, done, led1, led2
    );

endinterface

// File: rtl/countup_nbits_seg7_encoder.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes blank the digit.
//   i_bcd   : 4-bit BCD digit
//   o_seg_c : segment pattern (combinational)
module seg7_encoder
    import countup_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    output logic [SEG_W-1:0] o_seg_c
);

    // Table lookup; codes 10..15 fall through to blank
    always_comb begin
        o_seg_c = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (i_bcd == BCD_W'(i)) begin
                o_seg_c = SEG_DIGIT[i];
            end
        end
    end

endmodule

// File: rtl/countup_nbits.sv
// N-bit prescaled count-up timer: counts from 0 to a target latched at start,
// then holds and raises done. Count is also shown as two 7-segment digits.
//   clk, reset : clock, synchronous active-high reset
//   bus        : start/pause/target in; countupOut/done/led1/led2 out
module countup_nbits
    import countup_pkg::*;
#(
    parameter int unsigned N   = 6,
    parameter int unsigned DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    countup_nbits_if.slave   bus
);

    localparam int unsigned PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    state_t        r_state, w_state;
    logic [N-1:0]  r_count, w_count;
    logic [N-1:0]  r_target, w_target;
    logic [PW-1:0] r_presc, w_presc;
    logic          r_done, w_done;
    logic          w_step;

    logic [6:0]       w_count7;
    logic [BCD_W-1:0] w_tens, w_ones;
    logic [SEG_W-1:0] w_led1, w_led2;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_target <= '0;
            r_presc  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_count  <= w_count;
            r_target <= w_target;
            r_presc  <= w_presc;
            r_done   <= w_done;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state  = r_state;
        w_count  = r_count;
        w_target = r_target;
        w_presc  = r_presc;
        w_step   = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_target = bus.target;
                    w_count  = '0;
                    w_presc  = '0;
                    w_state  = (bus.target == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (bus.pause) begin
                    w_state = PAUSE;
                end else begin
                    w_step = 1'b1;
                end
            end
            PAUSE: begin
                // Resuming edge counts as a running edge, so a pause
                // costs exactly the number of cycles it was held
                if (!bus.pause) begin
                    w_state = RUN;
                    w_step  = 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase

        if (w_step) begin
            if (r_presc == PRESC_LAST) begin
                w_presc = '0;
                w_count = r_count + N'(1);
                if (w_count == r_target) begin
                    w_state = DONE;
                end
            end else begin
                w_presc = r_presc + PW'(1);
            end
        end

        w_done = (w_state == DONE);
    end

    // Binary to two BCD digits; count is at most 63
    assign w_count7 = 7'(r_count);
    assign w_tens   = BCD_W'(w_count7 / 7'd10);
    assign w_ones   = BCD_W'(w_count7 % 7'd10);

    seg7_encoder u_seg_ones (
        .i_bcd   (w_ones),
        .o_seg_c (w_led1)
    );

    seg7_encoder u_seg_tens (
        .i_bcd   (w_tens),
        .o_seg_c (w_led2)
    );

    assign bus.countupOut = r_count;
    assign bus.done       = r_done;
    assign bus.led1       = w_led1;
    assign bus.led2       = w_led2;

endmodule

// File: tb/tb_countup_nbits.sv
// Scoreboard bench for countup_nbits: three instances (N=6/DIV=1, N=6/DIV=3,
// N=2/DIV=1). Stimulus queues expected outputs per edge; a monitor compares.
module tb_countup_nbits;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        int         dut;
        int         cyc;
        int         cnt;
        bit         dn;
        logic [6:0] l1;
        logic [6:0] l2;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    countup_nbits_if #(.N(6)) b0 ();
    countup_nbits_if #(.N(6)) b1 ();
    countup_nbits_if #(.N(2)) b2 ();

    countup_nbits #(.N(6), .DIV(1)) u_dut0 (.clk(clk), .reset(reset), .bus(b0));
    countup_nbits #(.N(6), .DIV(3)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
    countup_nbits #(.N(2), .DIV(1)) u_dut2 (.clk(clk), .reset(reset), .bus(b2));

    initial begin
        clk = 1'b0;
        forever begin
            #5 clk = 1'b1;
            #5 clk = 1'b0;
        end
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'h40;  1: seg = 7'h79;  2: seg = 7'h24;  3: seg = 7'h30;
            4: seg = 7'h19;  5: seg = 7'h12;  6: seg = 7'h02;  7: seg = 7'h78;
            8: seg = 7'h00;  9: seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    endfunction

    task automatic expect_at(input int d, input int c, input int cnt, input bit dn,
                             input string nm);
        exp_t e;
        e.dut = d; e.cyc = c; e.cnt = cnt; e.dn = dn;
        e.l1 = seg(cnt % 10); e.l2 = seg(cnt / 10); e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Raise start on one instance; accepting edge is the next posedge
    task automatic start_on(input int d, input int tgt, input bit p, output int k);
        k = cyc + 1;
        case (d)
            0: begin b0.start = 1'b1; b0.target = 6'(tgt); b0.pause = p; end
            1: begin b1.start = 1'b1; b1.target = 6'(tgt); b1.pause = p; end
            default: begin b2.start = 1'b1; b2.target = 2'(tgt); b2.pause = p; end
        endcase
    endtask

    task automatic drop_start();
        @(negedge clk);
        b0.start = 1'b0; b1.start = 1'b0; b2.start = 1'b0;
    endtask

    // Monitor: compare every expectation due at this edge
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                int         a_cnt;
                bit         a_dn;
                logic [6:0] a_l1, a_l2;
                case (exp_q[i].dut)
                    0: begin a_cnt = int'(b0.countupOut); a_dn = b0.done;
                             a_l1 = b0.led1; a_l2 = b0.led2; end
                    1: begin a_cnt = int'(b1.countupOut); a_dn = b1.done;
                             a_l1 = b1.led1; a_l2 = b1.led2; end
                    default: begin a_cnt = int'(b2.countupOut); a_dn = b2.done;
                             a_l1 = b2.led1; a_l2 = b2.led2; end
                endcase
                checks++;
                if (a_cnt != exp_q[i].cnt || a_dn != exp_q[i].dn ||
                    a_l1 !== exp_q[i].l1 || a_l2 !== exp_q[i].l2) begin
                    errors++;
                    $display("FAIL %s (dut%0d edge %0d): got cnt=%0d done=%0b led1=%h led2=%h, want cnt=%0d done=%0b led1=%h led2=%h",
                             exp_q[i].name, exp_q[i].dut, cyc, a_cnt, a_dn, a_l1, a_l2,
                             exp_q[i].cnt, exp_q[i].dn, exp_q[i].l1, exp_q[i].l2);
                end
                exp_q.delete(i);
            end
        end
    end

    initial begin
        int k;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        b0.start = 1'b0; b0.pause = 1'b0; b0.target = '0;
        b1.start = 1'b0; b1.pause = 1'b0; b1.target = '0;
        b2.start = 1'b0; b2.pause = 1'b0; b2.target = '0;

        // Reset state
        @(negedge clk);
        for (int d = 0; d < 3; d++) expect_at(d, cyc + 1, 0, 1'b0, "reset_state");
        @(negedge clk);
        reset = 1'b0;

        // Basic run to 5, then hold
        start_on(0, 5, 1'b0, k);
        expect_at(0, k,      0, 1'b0, "basic_start");
        expect_at(0, k + 1,  1, 1'b0, "basic_first");
        expect_at(0, k + 4,  4, 1'b0, "basic_before_done");
        expect_at(0, k + 5,  5, 1'b1, "basic_done");
        expect_at(0, k + 25, 5, 1'b1, "basic_hold");
        drop_start();
        wait_to(k + 26);

        // Start during RUN is ignored, target change too
        start_on(0, 8, 1'b0, k);
        expect_at(0, k + 4, 4, 1'b0, "run_start_ignored");
        expect_at(0, k + 8, 8, 1'b1, "run_start_done");
        drop_start();
        wait_to(k + 3);
        b0.start = 1'b1; b0.target = 6'd2;
        drop_start();
        wait_to(k + 9);

        // Restart from DONE with target 2
        start_on(0, 2, 1'b0, k);
        expect_at(0, k,     0, 1'b0, "restart_zero");
        expect_at(0, k + 1, 1, 1'b0, "restart_one");
        expect_at(0, k + 2, 2, 1'b1, "restart_done");
        drop_start();
        wait_to(k + 4);

        // Pause for 4 cycles at count 4, target 10
        start_on(0, 10, 1'b0, k);
        expect_at(0, k + 5,  4,  1'b0, "pause_hold_a");
        expect_at(0, k + 8,  4,  1'b0, "pause_hold_b");
        expect_at(0, k + 9,  5,  1'b0, "pause_resume");
        expect_at(0, k + 13, 9,  1'b0, "pause_before_done");
        expect_at(0, k + 14, 10, 1'b1, "pause_done");
        drop_start();
        wait_to(k + 4);
        b0.pause = 1'b1;
        wait_to(k + 8);
        b0.pause = 1'b0;
        wait_to(k + 15);

        // Target 0 goes straight to DONE
        start_on(0, 0, 1'b0, k);
        expect_at(0, k,     0, 1'b1, "target0_done");
        expect_at(0, k + 3, 0, 1'b1, "target0_hold");
        drop_start();
        wait_to(k + 4);

        // Start and pause together from DONE
        start_on(0, 3, 1'b1, k);
        expect_at(0, k,     0, 1'b0, "simul_run");
        expect_at(0, k + 1, 0, 1'b0, "simul_paused");
        expect_at(0, k + 2, 0, 1'b0, "simul_paused2");
        expect_at(0, k + 3, 1, 1'b0, "simul_resume");
        expect_at(0, k + 5, 3, 1'b1, "simul_done");
        drop_start();
        wait_to(k + 2);
        b0.pause = 1'b0;
        wait_to(k + 6);

        // Reset held 2 cycles mid-run at count 7
        start_on(0, 20, 1'b0, k);
        expect_at(0, k + 7,  7, 1'b0, "midrun_count7");
        expect_at(0, k + 8,  0, 1'b0, "midrun_reset_a");
        expect_at(0, k + 9,  0, 1'b0, "midrun_reset_b");
        expect_at(0, k + 10, 0, 1'b0, "midrun_idle");
        drop_start();
        wait_to(k + 7);
        reset = 1'b1;
        wait_to(k + 9);
        reset = 1'b0;
        wait_to(k + 11);

        // Full range: DIV=3 to 63, and N=2 to 3 with no wrap
        start_on(1, 63, 1'b0, k);
        start_on(2, 3, 1'b0, k);
        expect_at(1, k,       0,  1'b0, "full_start");
        expect_at(1, k + 2,   0,  1'b0, "full_presc");
        expect_at(1, k + 3,   1,  1'b0, "full_first");
        expect_at(1, k + 6,   2,  1'b0, "full_second");
        expect_at(1, k + 188, 62, 1'b0, "full_before_done");
        expect_at(1, k + 189, 63, 1'b1, "full_done");
        expect_at(1, k + 200, 63, 1'b1, "full_hold");
        expect_at(2, k + 2,   2,  1'b0, "n2_two");
        expect_at(2, k + 3,   3,  1'b1, "n2_done");
        expect_at(2, k + 30,  3,  1'b1, "n2_no_wrap");
        drop_start();
        wait_to(k + 202);

        if (exp_q.size() != 0) begin
            errors += exp_q.size();
            $display("FAIL unchecked: %0d expectations never compared, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/countup_nbits.md
# countup_nbits

Parameterised N-bit count-up timer, the complement of the team's countdown timer. It starts at 0, counts up once per prescaled tick to a target latched at start, then holds and flags completion. The count is also driven as two 7-segment digits (`led1` ones, `led2` tens). It sits in the lab timer datapath beside the countdown block and shares its board display conventions.

## Interface
- `N`, default 6: count width. Legal range is 1..6, so the maximum value 63 fits in two decimal digits.
- `DIV`, default 1: prescaler. The count advances once every `DIV` clocks while running. Legal when `DIV` ≥ 1.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; overrides every other input.
- `start` in 1: level-sampled. In IDLE or DONE it latches `target`, clears the count and enters RUN.
- `pause` in 1: level. While high in RUN/PAUSE, the count and prescaler freeze.
- `target` in N: terminal value, sampled only on an accepted `start`.
- `countupOut` out N: current count, registered.
- `done` out 1: registered; high exactly while in DONE.
- `led1` out 7: ones digit of `countupOut`.
- `led2` out 7: tens digit of `countupOut`.

## Operation
- **Segment encoding:** active-low, bit0 = a … bit6 = g.
  - Digits 0–9 encode as 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10.
  - `led1`/`led2` are combinational from `countupOut`: binary to two BCD digits (tens = count/10, ones = count%10), then encoded.
- **FSM states:** IDLE, RUN, PAUSE, DONE.
  - IDLE: count 0, `done` 0. `start` → RUN (or DONE if latched target = 0).
  - RUN: prescaler increments. On `presc == DIV-1`: prescaler clears and count += 1. If the new count equals the target, go to DONE on the same edge. `pause` high → PAUSE (no increment that edge).
  - PAUSE: count and prescaler hold. `pause` low → RUN.
  - DONE: count holds at target, `done` 1. `start` → restart exactly as from IDLE.
- **`start` while in RUN/PAUSE:** ignored; `target` changes there are also ignored.
- **`start` and `pause` high together in IDLE/DONE:** `start` is accepted → RUN. The next edge goes to PAUSE if `pause` is still high.
- **Width rules:**
  - The prescaler is `$clog2(DIV)` bits, minimum 1.
  - The count never exceeds the latched target, so there is no wrap-around.
  - With target = 2^N−1, the count stops at the all-ones value.
- **Reset mid-operation:** on the next edge → IDLE, count 0, prescaler 0, latched target 0.

## Timing
- **Reset values:** `countupOut` 0, `done` 0, `led1` = `led2` = 0x40, state IDLE.
- **Start:** sampled at edge k gives RUN from k (count still 0). With `DIV`=1, count = 1 after edge k+1 and = T after edge k+T. `done` rises at edge k+T, in the same cycle `countupOut` = T.
- **General `DIV`:** the m-th increment lands at edge k + m·DIV.
- **Pause:** high at edge p freezes the count from p. Deasserted at edge q, RUN resumes and the prescaler continues from its frozen value. Total run time to DONE is extended by exactly q−p cycles.
- **Segments:** zero latency relative to `countupOut`.

## Structure
- **Package `countup_pkg`:**
  - `state_t` enum {IDLE, RUN, PAUSE, DONE}.
  - `SEG_DIGIT[0:9]` constant array of 7-bit active-low patterns.
  - `SEG_BLANK` = 0x7F.
- **Sub-module `seg7_encoder`:** 4-bit BCD in → 7-bit segments out, using `SEG_DIGIT`; input > 9 gives `SEG_BLANK`. Instantiated twice.
- **`countup_nbits` itself:** the FSM, prescaler, count register, target latch and BCD split.

## Test plan
- **Reset:** hold `reset` 2 cycles mid-run (count 7) → next edge gives `countupOut`=0, `done`=0, `led1`=`led2`=0x40.
- **Basic run:** N=6, DIV=1, target=5, `start` pulse at edge k → count reaches 5 at edge k+5. `done`=1 and `led1`=0x12 at that edge, and both hold for 20 cycles.
- **Full range:** N=6, DIV=3, target=63 → DONE after 189 cycles; `led2`=0x02, `led1`=0x30. Also N=2, target=3 → stops at 3 with no wrap.
- **Pause:** target=10, DIV=1, `pause` high for 4 cycles at count 4 → count holds at 4. DONE at edge k+14, `led2`=0x79, `led1`=0x40.
- **Edge cases:**
  - target=0 → DONE one edge after `start`, count 0.
  - `start` during RUN → ignored.
  - `start` while in DONE with target=2 → restarts from 0 and reaches 2 two edges later.
- **Simultaneous inputs:** `start` and `pause` high together in IDLE → RUN, then PAUSE with count 0. `pause` low → counting resumes.
